matrix_encoder_seq_ctrl: RTL and testbench
==========================================

# matrix_encoder_seq_ctrl

Parametrised sequencing controller for the matrix encoder datapath, successor to the fixed read/write/count controller. Walks an `N_WORDS`-entry source buffer: loads each word into the input register, waits a configurable read latency, and then writes the encoded result. It drives read/write addresses directly instead of relying on an external counter, and supports write-side backpressure. It sits between the top-level start/done interface and the input register / encoder / result memory.

## Interface
- `N_WORDS`, 16: words per job; legal range 1..2^`ADDR_W`.
- `ADDR_W`, 4: address and counter width.
- `RD_LAT`, 1: cycles from `inreg_en` to valid encoder output; legal range 1..8.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `out_ready`  in  1  write sink ready; a write completes in a cycle where `wr_en & out_ready`.
- `abort`  in  1  cancel the current job; present only with `MATRIX_ENC_ABORT_EN`.
- `inreg_en`  out  1  load the input register from `rd_addr`.
- `rd_addr`  out  `ADDR_W`  source word index.
- `wr_en`  out  1  result write request.
- `wr_addr`  out  `ADDR_W`  result word index.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse when the job completes.
- `aborted`  out  1  one-cycle pulse when a job is cancelled; present only with `MATRIX_ENC_ABORT_EN`.

## Operation
- Moore FSM: all outputs decode from state and registers only; no output is combinationally dependent on an input.
- Internal registers:
  - `cnt` is the word index.
  - `lat` is the wait counter, width clog2(`RD_LAT`)+1.
- States:
  - IDLE: `cnt`=0, `lat`=0, all outputs 0. Goes to FIRST_READ if `start`=1.
  - FIRST_READ: `inreg_en`=1, `rd_addr`=0, `busy`=1. Goes to WAIT if `RD_LAT`>1, otherwise to WRITE.
  - WAIT: `busy`=1. `lat` counts up to `RD_LAT`-1, then the FSM goes to WRITE and `lat` clears.
  - WRITE: `wr_en`=1, `wr_addr`=`cnt`, `busy`=1. The FSM holds here with `wr_addr` stable while `out_ready`=0. Once `out_ready`=1:
    - `cnt`=`N_WORDS`-1 → DONE.
    - otherwise → READ.
  - READ: `inreg_en`=1, `rd_addr`=`cnt`+1, `busy`=1. `cnt` increments on exit. Goes to WAIT if `RD_LAT`>1, otherwise to WRITE.
  - DONE: `done`=1, `busy`=0. Goes to IDLE unconditionally.
- Undefined state encodings go to IDLE.
- `start` outside IDLE is ignored and never queued. A `start` held high through DONE begins a new job on the cycle after DONE.
- `cnt` never wraps: comparison is exact against `N_WORDS`-1.
- `N_WORDS`=1 path: FIRST_READ → (WAIT) → WRITE → DONE.

## Timing
- Reset (`rst`=0) forces IDLE immediately and asynchronously. All outputs go to 0 and `cnt`=`lat`=0.
- Reset mid-job discards the job. No `done` or `aborted` pulse is produced.
- Latency, with `start` accepted at edge E and `out_ready` held at 1:
  - FIRST_READ is the cycle after E.
  - `done` is high in cycle E + `N_WORDS`·(`RD_LAT`+1) + 1.
  - Each stalled cycle in WRITE adds exactly one cycle.
- `inreg_en` is always exactly one cycle wide.
- `wr_en` rises exactly `RD_LAT` cycles after the `inreg_en` cycle for the same index.
- `busy` is high from FIRST_READ through the final WRITE and low in DONE and IDLE.

## Configuration
- `MATRIX_ENC_ABORT_EN` defined:
  - The `abort` input and `aborted` output exist.
  - `abort`=1 in any state other than IDLE or DONE sends the FSM to IDLE on the next edge. `aborted`=1 for that one IDLE cycle; `done` is not pulsed.
  - `abort` has priority over `out_ready` and `start`.
  - A write handshaken in the same cycle as `abort` is treated as complete by the sink, but the job still ends.
  - `abort` in IDLE or DONE is ignored.
- `MATRIX_ENC_ABORT_EN` undefined: both ports are absent and the FSM has no abort path.

## Test plan
- Reset then idle: `rst`=0 mid-WRITE (`N_WORDS`=16) → all outputs 0 in the same cycle. After release, `start`=0 → FSM stays IDLE with `busy`=0.
- Nominal run, `N_WORDS`=16, `RD_LAT`=1, `out_ready`=1 → 16 `inreg_en` pulses with `rd_addr` 0..15 and 16 writes with `wr_addr` 0..15. `done` is high exactly 33 cycles after the `start` edge.
- Latency parameter, `N_WORDS`=4, `RD_LAT`=3 → each `wr_en` is 3 cycles after its `inreg_en`. `done` arrives at cycle 17.
- Backpressure: `out_ready`=0 for 5 cycles at `wr_addr`=7 → `wr_en` stays high with `wr_addr` stable at 7. `done` is delayed by exactly 5 cycles. `start` pulsed mid-job is ignored.
- Single word, `N_WORDS`=1 → sequence FIRST_READ, WRITE at `wr_addr`=0, DONE. `start` held high → a second job starts in the cycle after DONE.
- With `MATRIX_ENC_ABORT_EN`, `abort`=1 in WAIT at `cnt`=9 → next cycle is IDLE with `aborted`=1 for one cycle, `done` never asserts, and the next `start` begins again at `rd_addr`=0.

Source files
------------

// File: rtl/matrix_encoder_seq_ctrl.sv
// matrix_encoder_seq_ctrl
// Sequencing controller for the matrix encoder datapath. Walks N_WORDS source
// words: load input register, wait RD_LAT cycles for the encoder, write the
// result (with sink backpressure), then pulse done.
// Optional feature: define MATRIX_ENC_ABORT_EN to add the abort input and the
// aborted pulse output.
module matrix_encoder_seq_ctrl #(
  parameter int N_WORDS = 16,
  parameter int ADDR_W  = 4,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
`ifdef MATRIX_ENC_ABORT_EN
  input  logic              abort,
`endif
  output logic              inreg_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
`ifdef MATRIX_ENC_ABORT_EN
  ,
  output logic              aborted
`endif
);

  localparam int LAT_W = $clog2(RD_LAT) + 1;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FIRST_READ = 3'd1;
  localparam logic [2:0] S_WAIT       = 3'd2;
  localparam logic [2:0] S_WRITE      = 3'd3;
  localparam logic [2:0] S_READ       = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
  // A load cycle is followed by WAIT only when the encoder needs extra cycles.
  localparam logic [2:0]        AFTER_RD = (RD_LAT > 1) ? S_WAIT : S_WRITE;
  // lat counts cycles since the load; the load cycle itself is count 0, so
  // WAIT starts at 1 and leaves when it reaches RD_LAT-1.
  localparam logic [LAT_W-1:0]  LAT_FROM_RD = (RD_LAT > 1) ? LAT_W'(1) : '0;

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [LAT_W-1:0]  lat, lat_n;
`ifdef MATRIX_ENC_ABORT_EN
  logic              aborted_q, aborted_n;
`endif

  // Next-state and next-register computation.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    state_n = state;
    cnt_n   = cnt;
    lat_n   = lat;
`ifdef MATRIX_ENC_ABORT_EN
    aborted_n = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        lat_n = '0;
        if (start) state_n = S_FIRST_READ;
      end
      S_FIRST_READ: begin
        lat_n   = LAT_FROM_RD;
        state_n = AFTER_RD;
      end
      S_WAIT: begin
        if (lat == LAT_LAST) begin
          lat_n   = '0;
          state_n = S_WRITE;
        end else begin
          lat_n = lat + LAT_W'(1);
        end
      end
      S_WRITE: begin
        // Hold with wr_addr stable until the sink takes the word.
        if (out_ready) state_n = (cnt == LAST_IDX) ? S_DONE : S_READ;
      end
      S_READ: begin
        cnt_n   = cnt + ADDR_W'(1);
        lat_n   = LAT_FROM_RD;
        state_n = AFTER_RD;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        lat_n   = '0;
      end
    endcase
`ifdef MATRIX_ENC_ABORT_EN
    // Cancel overrides every other transition of an active job.
    if (abort && (state != S_IDLE) && (state != S_DONE)) begin
      state_n   = S_IDLE;
      cnt_n     = '0;
      lat_n     = '0;
      aborted_n = 1'b1;
    end
`endif
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      lat   <= '0;
`ifdef MATRIX_ENC_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state <= state_n;
      cnt   <= cnt_n;
      lat   <= lat_n;
`ifdef MATRIX_ENC_ABORT_EN
      aborted_q <= aborted_n;
`endif
    end
  end

  // Moore output decode from state and registers only.
  always_comb begin
    inreg_en = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_FIRST_READ: begin
        inreg_en = 1'b1;
        busy     = 1'b1;
      end
      S_WAIT: begin
        busy = 1'b1;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        busy    = 1'b1;
      end
      S_READ: begin
        inreg_en = 1'b1;
        rd_addr  = cnt + ADDR_W'(1);
        busy     = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

`ifdef MATRIX_ENC_ABORT_EN
  // Cancel pulse: the register is only set on the edge into IDLE.
  assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_matrix_encoder_seq_ctrl.sv
// tb_matrix_encoder_seq_ctrl
// Drives four controller instances (different N_WORDS / RD_LAT) with shared
// stimulus and compares each against a word/position reference model.
// Optional: MATRIX_ENC_ABORT_EN adds the abort stimulus and checks.
module tb_matrix_encoder_seq_ctrl;

  localparam int NI = 4;

  function automatic int nw_of(input int i);
    case (i)
      0: return 16;
      1: return 4;
      2: return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0: return 1;
      1: return 3;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic out_ready;
`ifdef MATRIX_ENC_ABORT_EN
  logic abort;
  logic aborted_o [NI];
`endif

  logic       inreg_en_o [NI];
  logic [3:0] rd_addr_o  [NI];
  logic       wr_en_o    [NI];
  logic [3:0] wr_addr_o  [NI];
  logic       busy_o     [NI];
  logic       done_o     [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    matrix_encoder_seq_ctrl #(
      .N_WORDS(nw_of(g)),
      .ADDR_W (4),
      .RD_LAT (lat_of(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .out_ready(out_ready),
`ifdef MATRIX_ENC_ABORT_EN
      .abort    (abort),
`endif
      .inreg_en (inreg_en_o[g]),
      .rd_addr  (rd_addr_o[g]),
      .wr_en    (wr_en_o[g]),
      .wr_addr  (wr_addr_o[g]),
      .busy     (busy_o[g]),
      .done     (done_o[g])
`ifdef MATRIX_ENC_ABORT_EN
      ,
      .aborted  (aborted_o[g])
`endif
    );
  end

  int errors = 0;
  int checks = 0;

  // Reference model: job mode, word index k, position p within the word
  // (p=0 load, p=RD_LAT write, in between waiting).
  localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2;
  int m_mode [NI];
  int m_k    [NI];
  int m_p    [NI];
  bit m_ab   [NI];
  int n_rd   [NI];
  int n_wr   [NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = M_IDLE; m_k[i] = 0; m_p[i] = 0; m_ab[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit ab_in;
`ifdef MATRIX_ENC_ABORT_EN
    ab_in = abort;
`else
    ab_in = 1'b0;
`endif
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        m_mode[i] = M_IDLE; m_k[i] = 0; m_p[i] = 0; m_ab[i] = 1'b0;
      end else begin
        m_ab[i] = 1'b0;
        case (m_mode[i])
          M_IDLE: if (start) begin m_mode[i] = M_ACT; m_k[i] = 0; m_p[i] = 0; end
          M_ACT: begin
            if (ab_in) begin
              m_mode[i] = M_IDLE; m_ab[i] = 1'b1;
            end else if (m_p[i] < lat_of(i)) begin
              m_p[i]++;
            end else if (out_ready) begin
              if (m_k[i] == nw_of(i) - 1) m_mode[i] = M_DONE;
              else begin m_k[i]++; m_p[i] = 0; end
            end
          end
          default: m_mode[i] = M_IDLE;
        endcase
      end
    end
  endtask

  task automatic check_all();
    bit act, exp_in, exp_wr;
    for (int i = 0; i < NI; i++) begin
      act    = (m_mode[i] == M_ACT);
      exp_in = act && (m_p[i] == 0);
      exp_wr = act && (m_p[i] == lat_of(i));
      check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(act));
      check($sformatf("inreg_en[%0d]", i), 32'(inreg_en_o[i]), 32'(exp_in));
      check($sformatf("wr_en[%0d]", i), 32'(wr_en_o[i]), 32'(exp_wr));
      check($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(m_mode[i] == M_DONE));
      if (exp_in) check($sformatf("rd_addr[%0d]", i), 32'(rd_addr_o[i]), m_k[i]);
      if (exp_wr) check($sformatf("wr_addr[%0d]", i), 32'(wr_addr_o[i]), m_k[i]);
      if (m_mode[i] == M_IDLE) begin
        check($sformatf("idle_rd_addr[%0d]", i), 32'(rd_addr_o[i]), 0);
        check($sformatf("idle_wr_addr[%0d]", i), 32'(wr_addr_o[i]), 0);
      end
`ifdef MATRIX_ENC_ABORT_EN
      check($sformatf("aborted[%0d]", i), 32'(aborted_o[i]),
            32'((m_mode[i] == M_IDLE) && m_ab[i]));
`endif
    end
  endtask

  // One clock: compare current outputs, tally handshakes, advance the model.
  task automatic cycle();
    check_all();
    for (int i = 0; i < NI; i++) begin
      if (inreg_en_o[i]) n_rd[i]++;
      if (wr_en_o[i] && out_ready) n_wr[i]++;
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    start = 1'b0;
    out_ready = 1'b1;
`ifdef MATRIX_ENC_ABORT_EN
    abort = 1'b0;
`endif
    repeat (60) cycle();
  endtask

  initial begin
    int k;
    int t_done [NI];
    int d_first, d_cnt;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
`ifdef MATRIX_ENC_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < NI; i++) begin n_rd[i] = 0; n_wr[i] = 0; end
    model_reset();
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("por_busy[%0d]", i), 32'(busy_o[i]), 0);
      check($sformatf("por_inreg[%0d]", i), 32'(inreg_en_o[i]), 0);
      check($sformatf("por_wr_en[%0d]", i), 32'(wr_en_o[i]), 0);
      check($sformatf("por_done[%0d]", i), 32'(done_o[i]), 0);
    end
    @(posedge clk); #1;
    cycle();
    rst = 1'b1;
    repeat (3) cycle();

    // Nominal run: done latency from the start edge per instance.
    for (int i = 0; i < NI; i++) begin n_rd[i] = 0; n_wr[i] = 0; t_done[i] = -1; end
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      for (int i = 0; i < NI; i++)
        if (done_o[i] && t_done[i] < 0) t_done[i] = t;
      cycle();
    end
    for (int i = 0; i < NI; i++)
      check($sformatf("done_latency[%0d]", i), t_done[i], nw_of(i) * (lat_of(i) + 1) + 1);
    check("nominal_reads[0]", n_rd[0], 16);
    check("nominal_writes[0]", n_wr[0], 16);
    check("nominal_reads[1]", n_rd[1], 4);
    check("nominal_writes[1]", n_wr[1], 4);

    // Backpressure at wr_addr 7 for five cycles, with a stray start mid-job.
    drain();
    start = 1'b1;
    cycle();
    start = 1'b0;
    k = 1;
    while (!(wr_en_o[0] && wr_addr_o[0] == 4'd7) && k < 100) begin cycle(); k++; end
    check("bp_reach_addr7", 32'(wr_en_o[0] && wr_addr_o[0] == 4'd7), 1);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("bp_wr_en_hold", 32'(wr_en_o[0]), 1);
      check("bp_wr_addr_hold", 32'(wr_addr_o[0]), 7);
      start = (s == 2);
      cycle();
      k++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    while (!done_o[0] && k < 100) begin cycle(); k++; end
    check("bp_done_latency", k, 38);

    // Single word with start held: back-to-back jobs on instance 2.
    drain();
    d_first = -1; d_cnt = 0;
    start = 1'b1;
    cycle();
    for (int t = 1; t <= 8; t++) begin
      if (done_o[2]) begin
        d_cnt++;
        if (d_first < 0) d_first = t;
        else check("single_redo_spacing", t - d_first, 4);
      end
      cycle();
    end
    start = 1'b0;
    check("single_done_count", d_cnt, 2);

    // Asynchronous reset in the middle of a write.
    drain();
    start = 1'b1;
    cycle();
    start = 1'b0;
    k = 1;
    while (!wr_en_o[0] && k < 50) begin cycle(); k++; end
    check("rst_reach_write", 32'(wr_en_o[0]), 1);
    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_busy[%0d]", i), 32'(busy_o[i]), 0);
      check($sformatf("rst_wr_en[%0d]", i), 32'(wr_en_o[i]), 0);
      check($sformatf("rst_wr_addr[%0d]", i), 32'(wr_addr_o[i]), 0);
      check($sformatf("rst_inreg[%0d]", i), 32'(inreg_en_o[i]), 0);
      check($sformatf("rst_done[%0d]", i), 32'(done_o[i]), 0);
    end
    model_reset();
    cycle();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cycle();
      check("post_rst_idle", 32'(busy_o[0]), 0);
    end

    // Randomised traffic against the model.
    for (int s = 0; s < 250; s++) begin
      start = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MATRIX_ENC_ABORT_EN
      abort = ($urandom_range(0, 31) == 0);
`endif
      cycle();
    end

`ifdef MATRIX_ENC_ABORT_EN
    // Abort during WAIT at word 9 of instance 3.
    drain();
    start = 1'b1;
    cycle();
    start = 1'b0;
    k = 1;
    while (!(inreg_en_o[3] && rd_addr_o[3] == 4'd9) && k < 100) begin cycle(); k++; end
    check("ab_reach_rd9", 32'(inreg_en_o[3] && rd_addr_o[3] == 4'd9), 1);
    cycle();
    check("ab_in_wait", 32'(busy_o[3] && !inreg_en_o[3] && !wr_en_o[3]), 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("ab_pulse", 32'(aborted_o[3]), 1);
    check("ab_idle_busy", 32'(busy_o[3]), 0);
    d_cnt = 0;
    for (int s = 0; s < 60; s++) begin
      cycle();
      if (done_o[3] || aborted_o[3]) d_cnt++;
    end
    check("ab_no_done", d_cnt, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("ab_restart_inreg", 32'(inreg_en_o[3]), 1);
    check("ab_restart_addr", 32'(rd_addr_o[3]), 0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
